median_leftmost_cell: RTL and testbench
=======================================

// Module: median_leftmost_cell
// PURPOSE
//  Left-end cell of the variable-size median filter sorting chain. The chain
//  is sorted ascending from left to right. This cell owns the smallest value
//  and its age. It generates the compare/oldest flags that the right
//  neighbours consume as Ti_L/Z_L.
//  It also owns the window fill count and the handshake for the whole chain.
// PARAMETERS
//  DW    8   sample width, unsigned
//  MAXW  16  maximum window size (cells in chain)
//  AW    $clog2(MAXW)+1  width of age/fill/win_size fields
// PORTS
//  clk       in   1   clock, rising edge
//  rst_n     in   1   asynchronous active-low reset
//  in_valid  in   1   new sample X offered
//  in_ready  out  1   cell accepts X this cycle
//  x_in      in   DW  new sample X
//  win_size  in   AW  window size N; 0 treated as 1, >MAXW clamped to MAXW
//  r_val     in   DW  right neighbour value
//  r_age     in   AW  right neighbour age
//  r_vld     in   1   right neighbour holds a sample
//  r_t       in   1   right neighbour T flag (r_val > X, or r_vld=0)
//  val_out   out  DW  registered cell value
//  age_out   out  AW  registered cell age
//  vld_out   out  1   cell holds a sample
//  t_out     out  1   T0 = !vld_out | (val_out > x_in), combinational
//  z_out     out  1   Z0 = oldest sample is in this cell, combinational
//  s         out  2   update select: 00 hold, 01 load X, 10 take right
//  full      out  1   fill_cnt == N (window full)
//  upd_valid out  1   one-cycle pulse, the cycle after each accepted sample
// BEHAVIOUR
//  Reset: val_out=0, age_out=0, vld_out=0, fill_cnt=0, full=0, upd_valid=0,
//    in_ready=0. in_ready goes to 1 on the first clock after rst_n deasserts.
//  Handshake: a sample is accepted when in_valid & in_ready. There is one
//    sample per accepted cycle, with no backpressure except the flush cycle.
//  z_out = full & vld_out & (age_out == N-1). While not full, nothing is
//    removed.
//  Select on an accepted cycle (otherwise s=00):
//    z_out=1: r_t ? 01 : 10. The oldest sample leaves the chain; the cell
//      either takes X or shifts left.
//    z_out=0: t_out ? 01 : 00. On 01, X is inserted here and the chain
//      shifts right.
//  Register update on an accepted cycle:
//    01 -> val=x_in, age=0, vld=1
//    10 -> val=r_val, age=r_age+1, vld=r_vld
//    00 -> age=age+1 if vld, else unchanged
//  Ages saturate at MAXW-1.
//  fill_cnt increments per accepted sample until it reaches N, then holds.
//  full is registered.
//  Ties: X equal to val_out gives T0=0, so X goes right of equal values.
//  N=1: r_* are tied off (r_vld=0, r_t=1). From the 2nd sample onward every
//    accept gives z_out=1 and s=01.
//  win_size change: the value is registered each cycle as win_q. When
//    win_size != win_q, that cycle is a flush cycle:
//    in_ready=0, no accept.
//    Next edge: vld=0, age=0, fill_cnt=0, full=0.
//    Fill then restarts.
//  Reset mid-operation: all state is cleared asynchronously. No upd_valid
//    pulse is issued for an in-flight sample.
//  upd_valid is asserted the cycle after an accept, when the new val_out is
//    visible.
// STRUCTURE
//  Shared package median_pkg holds:
//    SEL_HOLD=2'b00, SEL_LOADX=2'b01, SEL_RIGHT=2'b10
//    DW/MAXW defaults and the AW function
//  The right-end control uses the same package.
//  One sub-module, median_leftmost_ctrl: combinational select from
//    {z_out, t_out, r_t, accept}.
//  The parent holds the registers, fill/flush logic and handshake.
// TESTING
//  1 Reset, N=4, feed 5,3,9,1, r_* from a model chain -> s=01,01,00,01;
//    full=1 after the 4th; val_out=1.
//  2 Full N=4, cell age=3 (oldest), X=7, r_val=2, r_t=0 -> s=10, val_out=2,
//    age_out=r_age+1.
//  3 Full N=4, cell oldest, X=1, r_t=1 -> s=01, val_out=1, age_out=0.
//  4 Tie: val_out=5, X=5, not oldest -> t_out=0, s=00, age increments.
//  5 win_size 4->2 mid-stream with in_valid=1 -> in_ready=0 for one cycle,
//    then vld_out=0, fill_cnt=0; refill 8,6 -> full=1, val_out=6.
//  6 Assert rst_n=0 mid-accept -> all outputs zero immediately;
//    no upd_valid pulse.

Source files
------------

// File: rtl/median_pkg.sv
// Shared definitions for the median filter sorting chain: update-select codes,
// default sizes and the width helper for the age/fill/window fields.
package median_pkg;

  localparam int DW_DEF   = 8;
  localparam int MAXW_DEF = 16;

  // Update-select codes driven to each cell of the chain.
  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LOADX = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;

  // Field width able to hold values 0..maxw inclusive.
  function automatic int calc_aw(input int maxw);
    return $clog2(maxw) + 1;
  endfunction

endpackage

// File: rtl/median_leftmost_ctrl.sv
// Update-select decode for the left-end cell: decides whether the cell holds,
// loads the new sample, or takes its right neighbour's contents.
module median_leftmost_ctrl
  import median_pkg::*;
(
  input  logic       accept,
  input  logic       z,
  input  logic       t,
  input  logic       r_t,
  output logic [1:0] s
);

  always_comb begin
    // NOTE: default first so every path assigns s; otherwise a latch is inferred.
    s = SEL_HOLD;
    if (accept) begin
      if (z) begin
        // Oldest sample leaves from here: take X if it belongs here, else shift left.
        s = r_t ? SEL_LOADX : SEL_RIGHT;
      end else if (t) begin
        s = SEL_LOADX;
      end
    end
  end

endmodule

// File: rtl/median_leftmost_cell.sv
// Left-end cell of the median sorting chain: holds the smallest value and its
// age, and owns window fill count, window-size flush and the input handshake.
module median_leftmost_cell
  import median_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int MAXW = MAXW_DEF,
  parameter int AW   = calc_aw(MAXW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_in,
  input  logic [AW-1:0] win_size,
  input  logic [DW-1:0] r_val,
  input  logic [AW-1:0] r_age,
  input  logic          r_vld,
  input  logic          r_t,
  output logic [DW-1:0] val_out,
  output logic [AW-1:0] age_out,
  output logic          vld_out,
  output logic          t_out,
  output logic          z_out,
  output logic [1:0]    s,
  output logic          full,
  output logic          upd_valid
);

  localparam logic [AW-1:0] MAXW_C  = AW'(MAXW);
  localparam logic [AW-1:0] AGE_MAX = AW'(MAXW - 1);

  logic [AW-1:0] win_q;
  logic [AW-1:0] n_eff;
  logic [AW-1:0] fill_cnt;
  logic [AW-1:0] fill_next;
  logic          rdy_q;
  logic          flush;
  logic          accept;

  function automatic logic [AW-1:0] age_inc(input logic [AW-1:0] a);
    return (a >= AGE_MAX) ? AGE_MAX : a + 1'b1;
  endfunction

  // Effective window size from the registered request: 0 means 1, clamp at MAXW.
  always_comb begin
    n_eff = win_q;
    if (win_q == '0) begin
      n_eff = AW'(1);
    end else if (win_q > MAXW_C) begin
      n_eff = MAXW_C;
    end
  end

  assign flush     = (win_size != win_q);
  assign in_ready  = rdy_q & ~flush;
  assign accept    = in_valid & in_ready;

  assign t_out     = ~vld_out | (val_out > x_in);
  assign z_out     = full & vld_out & (age_out == n_eff - 1'b1);
  assign fill_next = (fill_cnt != n_eff) ? fill_cnt + 1'b1 : fill_cnt;

  median_leftmost_ctrl u_ctrl (
    .accept (accept),
    .z      (z_out),
    .t      (t_out),
    .r_t    (r_t),
    .s      (s)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_out   <= '0;
      age_out   <= '0;
      vld_out   <= 1'b0;
      fill_cnt  <= '0;
      full      <= 1'b0;
      upd_valid <= 1'b0;
      rdy_q     <= 1'b0;
      win_q     <= '0;
    end else begin
      win_q     <= win_size;
      rdy_q     <= 1'b1;
      upd_valid <= accept;
      if (flush) begin
        // Window size changed: empty the cell and restart filling.
        vld_out  <= 1'b0;
        age_out  <= '0;
        fill_cnt <= '0;
        full     <= 1'b0;
      end else if (accept) begin
        case (s)
          SEL_LOADX: begin
            val_out <= x_in;
            age_out <= '0;
            vld_out <= 1'b1;
          end
          SEL_RIGHT: begin
            val_out <= r_val;
            age_out <= age_inc(r_age);
            vld_out <= r_vld;
          end
          default: begin
            if (vld_out) age_out <= age_inc(age_out);
          end
        endcase
        fill_cnt <= fill_next;
        full     <= (fill_next == n_eff);
      end
    end
  end

endmodule

// File: tb/tb_median_leftmost_cell.sv
// Scoreboard bench for median_leftmost_cell: directed samples push expected
// post-update state; a monitor pops and compares on each upd_valid pulse.
module tb_median_leftmost_cell;

  localparam int DW = 8;
  localparam int MAXW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_in;
  logic [AW-1:0] win_size;
  logic [DW-1:0] r_val;
  logic [AW-1:0] r_age;
  logic          r_vld;
  logic          r_t;
  logic [DW-1:0] val_out;
  logic [AW-1:0] age_out;
  logic          vld_out;
  logic          t_out;
  logic          z_out;
  logic [1:0]    s;
  logic          full;
  logic          upd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0] v;
    logic [AW-1:0] a;
    logic          f;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  median_leftmost_cell #(.DW(DW), .MAXW(MAXW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .win_size  (win_size),
    .r_val     (r_val),
    .r_age     (r_age),
    .r_vld     (r_vld),
    .r_t       (r_t),
    .val_out   (val_out),
    .age_out   (age_out),
    .vld_out   (vld_out),
    .t_out     (t_out),
    .z_out     (z_out),
    .s         (s),
    .full      (full),
    .upd_valid (upd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every upd_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (upd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("upd_valid_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_val", 32'(val_out), 32'(mon_e.v));
        check("mon_age", 32'(age_out), 32'(mon_e.a));
        check("mon_vld", 32'(vld_out), 1);
        check("mon_full", 32'(full), 32'(mon_e.f));
      end
    end
  end

  // Offer one sample with the given right-neighbour view; check the
  // combinational flags and select, and queue the expected resulting state.
  task automatic send(input string tag,
                      input logic [DW-1:0] x, input logic [DW-1:0] rv,
                      input logic [AW-1:0] ra, input logic rvl, input logic rt,
                      input logic [1:0] es, input logic et, input logic ez,
                      input logic [DW-1:0] ev, input logic [AW-1:0] ea, input logic ef);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = x;
    r_val    = rv;
    r_age    = ra;
    r_vld    = rvl;
    r_t      = rt;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_t"}, 32'(t_out), 32'(et));
    check({tag, "_z"}, 32'(z_out), 32'(ez));
    check({tag, "_s"}, 32'(s), 32'(es));
    e.v = ev;
    e.a = ea;
    e.f = ef;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Change the window size while a sample is offered; expect one refused cycle
  // and an emptied cell afterwards.
  task automatic flush_to(input string tag, input logic [AW-1:0] n);
    @(negedge clk);
    win_size = n;
    in_valid = 1'b1;
    x_in     = 8'd99;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_s"}, 32'(s), 0);
    @(posedge clk);
    #1;
    check({tag, "_vld"}, 32'(vld_out), 0);
    check({tag, "_age"}, 32'(age_out), 0);
    check({tag, "_full"}, 32'(full), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    x_in     = '0;
    win_size = 5'd4;
    r_val    = '0;
    r_age    = '0;
    r_vld    = 1'b0;
    r_t      = 1'b1;
    #1;
    check("rst_val", 32'(val_out), 0);
    check("rst_age", 32'(age_out), 0);
    check("rst_vld", 32'(vld_out), 0);
    check("rst_full", 32'(full), 0);
    check("rst_upd", 32'(upd_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    #21 rst_n = 1'b1;
    #1 check("rel_in_ready_before_edge", 32'(in_ready), 0);
    @(posedge clk);
    #1 check("rel_in_ready_after_edge", 32'(in_ready), 1);

    // Fill N=4 with 5,3,9,1; chain view to the right is hand-tracked.
    send("f1", 8'd5, 8'd0, 5'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'd5, 5'd0, 1'b0);
    send("f2", 8'd3, 8'd0, 5'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'd3, 5'd0, 1'b0);
    send("f3", 8'd9, 8'd5, 5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd3, 5'd1, 1'b0);
    send("f4", 8'd1, 8'd5, 5'd2, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 8'd1, 5'd0, 1'b1);
    // Age the cell to N-1 with larger samples.
    send("a1", 8'd6, 8'd3, 5'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd1, 5'd1, 1'b1);
    send("a2", 8'd6, 8'd3, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd1, 5'd2, 1'b1);
    send("a3", 8'd6, 8'd6, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd1, 5'd3, 1'b1);
    // Oldest here, X goes right: take neighbour, age r_age+1.
    send("old_right", 8'd7, 8'd2, 5'd1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 8'd2, 5'd2, 1'b1);
    send("age_up", 8'd9, 8'd6, 5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd2, 5'd3, 1'b1);
    // Oldest here, X is smallest: load X in place.
    send("old_loadx", 8'd1, 8'd3, 5'd2, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 8'd1, 5'd0, 1'b1);
    // Tie: X equal to cell value goes right, cell ages.
    send("tie", 8'd1, 8'd6, 5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd1, 5'd1, 1'b1);

    // Window 4 -> 2 with a sample pending, then refill.
    flush_to("flush2", 5'd2);
    send("r1", 8'd8, 8'd0, 5'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'd8, 5'd0, 1'b0);
    send("r2", 8'd6, 8'd0, 5'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'd6, 5'd0, 1'b1);

    // Window 0 behaves as N=1: every sample after the first replaces the cell.
    flush_to("flush0", 5'd0);
    send("n1_a", 8'd4, 8'd0, 5'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'd4, 5'd0, 1'b1);
    send("n1_b", 8'd7, 8'd0, 5'd0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 8'd7, 5'd0, 1'b1);
    send("n1_c", 8'd2, 8'd0, 5'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'd2, 5'd0, 1'b1);

    // Reset while a sample is being accepted.
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = 8'd3;
    r_vld    = 1'b0;
    r_t      = 1'b1;
    #1 check("mid_in_ready", 32'(in_ready), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_val", 32'(val_out), 0);
    check("mid_rst_vld", 32'(vld_out), 0);
    check("mid_rst_full", 32'(full), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    check("mid_rst_upd", 32'(upd_valid), 0);
    check("mid_rst_age", 32'(age_out), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1 check("mid_rel_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 check("mid_rel_in_ready_edge", 32'(in_ready), 1);
    send("post_rst", 8'd5, 8'd0, 5'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'd5, 5'd0, 1'b1);

    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
